// File: rtl/push_crc_sequencer.sv
// push_crc_sequencer: builds one packet per start request.
// The packet is len_a words from source A, then len_b words from source B,
// then one CRC-8 word (MSB-first, non-reflected) over every forwarded word.
// The PUSH states are a zero-latency pass-through, so data and valid come
// straight from the active source and its ready is the sink's ready.
module push_crc_sequencer #(
    parameter int         LW       = 8,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [LW-1:0] len_a,
    input  logic [LW-1:0] len_b,
    output logic          busy,
    output logic          done,
    input  logic [7:0]    a_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [7:0]    b_data,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PUSH_A = 2'd1,
        S_PUSH_B = 2'd2,
        S_CRC    = 2'd3
    } state_t;

    localparam logic [LW-1:0] CNT_ONE = 1;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_a_q, len_a_d;
    logic [LW-1:0] len_b_q, len_b_d;
    logic [7:0]    crc_q, crc_d;
    logic          done_q, done_d;

    // One byte folded into the running CRC, most significant bit first.
    function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
        return c;
    endfunction

    // State, counter, CRC and latched lengths; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_a_q <= '0;
            len_b_q <= '0;
            crc_q   <= CRC_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_a_q <= len_a_d;
            len_b_q <= len_b_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic plus the output mux for the shared packet port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_a_d = len_a_q;
        len_b_d = len_b_q;
        crc_d   = crc_q;
        done_d  = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        o_data  = 8'h00;
        o_valid = 1'b0;
        o_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_a_d = len_a;
                    len_b_d = len_b;
                    cnt_d   = '0;
                    crc_d   = CRC_INIT;
                    if (len_a != '0)      state_d = S_PUSH_A;
                    else if (len_b != '0) state_d = S_PUSH_B;
                    else                  state_d = S_CRC;
                end
            end
            S_PUSH_A: begin
                o_data  = a_data;
                o_valid = a_valid;
                a_ready = o_ready;
                if (a_valid && o_ready) begin
                    crc_d = crc8(crc_q, a_data);
                    // Compare against len-1 before incrementing so cnt never wraps.
                    if (cnt_q == len_a_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = (len_b_q != '0) ? S_PUSH_B : S_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_PUSH_B: begin
                o_data  = b_data;
                o_valid = b_valid;
                b_ready = o_ready;
                if (b_valid && o_ready) begin
                    crc_d = crc8(crc_q, b_data);
                    if (cnt_q == len_b_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_CRC: begin
                // CRC word is held from the register, so it stays stable under backpressure.
                o_data  = crc_q;
                o_valid = 1'b1;
                o_last  = 1'b1;
                if (o_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_push_crc_sequencer.sv
// Testbench for push_crc_sequencer: directed packets from the test plan plus
// randomized packets, checked against a polynomial-division CRC reference.
module tb_push_crc_sequencer;

    localparam int LW = 8;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [LW-1:0] len_a;
    logic [LW-1:0] len_b;
    logic          busy;
    logic          done;
    logic [7:0]    a_data;
    logic          a_valid;
    logic          a_ready;
    logic [7:0]    b_data;
    logic          b_valid;
    logic          b_ready;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_buf [0:255];
    logic [7:0] b_buf [0:255];
    logic [7:0] msg   [0:511];
    logic [7:0] crc_seen;

    push_crc_sequencer #(.LW(LW), .CRC_POLY(8'h07), .CRC_INIT(8'h00)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .len_a   (len_a),
        .len_b   (len_b),
        .busy    (busy),
        .done    (done),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: remainder of M(x)*x^8 divided by x^8+x^2+x+1 (initial value 0).
    function automatic logic [7:0] ref_crc(input int n);
        logic [8:0] rem;
        rem = 9'h000;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                rem = {rem[7:0], msg[i][b]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        for (int k = 0; k < 8; k++) begin
            rem = {rem[7:0], 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    // Runs one packet from a negedge. Returns at the negedge of the first IDLE
    // cycle (done expected high), or right after a reset abort.
    task automatic run_packet(input int la, input int lb, input bit bp, input bit inject,
                              input int abort_at, output logic [7:0] crc_out);
        int         out_idx;
        int         cycles;
        int         phase;
        bit         xfer;
        bit         got_last;
        logic [7:0] exp_crc;
        logic [7:0] exp_word;

        for (int i = 0; i < la; i++) msg[i] = a_buf[i];
        for (int i = 0; i < lb; i++) msg[la + i] = b_buf[i];
        exp_crc  = ref_crc(la + lb);
        crc_out  = 8'hxx;
        out_idx  = 0;
        cycles   = 0;
        got_last = 1'b0;

        start   = 1'b1;
        len_a   = LW'(la);
        len_b   = LW'(lb);
        a_valid = 1'b0;
        b_valid = 1'b0;
        o_ready = 1'b0;
        #1;
        chk("busy_before_start", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;

        while (!got_last && cycles < 2000) begin
            // Lengths change after acceptance; they must not affect this packet.
            len_a   = LW'($urandom_range(0, 255));
            len_b   = LW'($urandom_range(0, 255));
            o_ready = bp ? cycles[0] : 1'b1;
            a_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            b_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_data  = (out_idx < la) ? a_buf[out_idx] : 8'($urandom);
            b_data  = (out_idx >= la && out_idx < la + lb) ? b_buf[out_idx - la] : 8'($urandom);
            start   = inject && (out_idx == la + 1) && (out_idx < la + lb);
            if (start) begin
                len_a = 8'd3;
                len_b = 8'd2;
            end
            if (abort_at >= 0 && out_idx == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_o_valid", o_valid, 1'b0);
                chk("abort_a_ready", a_ready, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_o_data", o_data, 8'h00);
                @(negedge clk);
                chk("abort_hold_busy", busy, 1'b0);
                rstn    = 1'b1;
                start   = 1'b0;
                a_valid = 1'b0;
                b_valid = 1'b0;
                return;
            end
            #1;
            chk("busy_in_packet", busy, 1'b1);
            chk("done_in_packet", done, 1'b0);
            phase = (out_idx < la) ? 0 : (out_idx < la + lb) ? 1 : 2;
            if (phase == 0) begin
                chk("a_phase_a_ready", a_ready, o_ready);
                chk("a_phase_b_ready", b_ready, 1'b0);
                chk("a_phase_o_valid", o_valid, a_valid);
                chk("a_phase_o_last", o_last, 1'b0);
                xfer     = a_valid && o_ready;
                exp_word = a_buf[out_idx];
            end else if (phase == 1) begin
                chk("b_phase_a_ready", a_ready, 1'b0);
                chk("b_phase_b_ready", b_ready, o_ready);
                chk("b_phase_o_valid", o_valid, b_valid);
                chk("b_phase_o_last", o_last, 1'b0);
                xfer     = b_valid && o_ready;
                exp_word = b_buf[out_idx - la];
            end else begin
                chk("crc_phase_a_ready", a_ready, 1'b0);
                chk("crc_phase_b_ready", b_ready, 1'b0);
                chk("crc_phase_o_valid", o_valid, 1'b1);
                chk("crc_phase_o_last", o_last, 1'b1);
                chk("crc_word_stable", o_data, exp_crc);
                xfer     = o_ready;
                exp_word = exp_crc;
            end
            if (xfer) begin
                chk("word_data", o_data, exp_word);
                $display("xfer word=%0d data=%02h last=%0b", out_idx, o_data, o_last);
                if (phase == 2) begin
                    crc_out  = o_data;
                    got_last = 1'b1;
                end
                out_idx++;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("packet_timeout", got_last, 1'b1);
        if (!bp) chk("busy_cycle_count", cycles, la + lb + 1);
        chk("done_pulse", done, 1'b1);
        chk("busy_after_done", busy, 1'b0);
        chk("o_valid_after_done", o_valid, 1'b0);
        $display("packet la=%0d lb=%0d crc=%02h cycles=%0d", la, lb, crc_out, cycles);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) a_buf[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 5; i++) b_buf[i] = 8'h35 + 8'(i);
    endtask

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        len_a   = '0;
        len_b   = '0;
        a_data  = 8'h00;
        a_valid = 1'b0;
        b_data  = 8'h00;
        b_valid = 1'b0;
        o_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_last", o_last, 1'b0);
        chk("rst_o_data", o_data, 8'h00);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic 4+5 packet, no backpressure
        load_basic();
        run_packet(4, 5, 1'b0, 1'b0, -1, crc_seen);
        chk("basic_crc", crc_seen, 8'hF4);

        // Same data with backpressure; start lands in the cycle done is high
        run_packet(4, 5, 1'b1, 1'b0, -1, crc_seen);
        chk("bp_crc", crc_seen, 8'hF4);

        // Zero-length A
        b_buf[0] = 8'h01;
        b_buf[1] = 8'h02;
        b_buf[2] = 8'h03;
        run_packet(0, 3, 1'b0, 1'b0, -1, crc_seen);

        // Both lengths zero: single CRC_INIT word
        run_packet(0, 0, 1'b0, 1'b0, -1, crc_seen);
        chk("zero_len_crc", crc_seen, 8'h00);

        // start pulsed during PUSH_B is ignored, then a fresh packet follows
        for (int i = 0; i < 3; i++) a_buf[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) b_buf[i] = 8'($urandom);
        run_packet(3, 4, 1'b0, 1'b1, -1, crc_seen);
        load_basic();
        run_packet(4, 5, 1'b0, 1'b0, -1, crc_seen);
        chk("fresh_crc", crc_seen, 8'hF4);

        // Reset after the 2nd A word, then a clean 4+5 packet
        run_packet(4, 5, 1'b0, 1'b0, 2, crc_seen);
        run_packet(4, 5, 1'b0, 1'b0, -1, crc_seen);
        chk("post_abort_crc", crc_seen, 8'hF4);

        // Randomized packets
        for (int p = 0; p < 8; p++) begin
            int la;
            int lb;
            la = $urandom_range(0, 7);
            lb = $urandom_range(0, 7);
            for (int i = 0; i < la; i++) a_buf[i] = 8'($urandom);
            for (int i = 0; i < lb; i++) b_buf[i] = 8'($urandom);
            run_packet(la, lb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, crc_seen);
        end

        // done must drop after a single cycle
        @(negedge clk);
        chk("done_single_cycle", done, 1'b0);
        chk("idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
